// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: buffered UART transmitter with a TX FIFO and per-frame
// configuration (5-8 data bits, none/even/odd parity, 1 or 2 stop bits).
// Each bit lasts 16 oversample ticks, and one tick occurs every div+1 clocks.
module uart_tx_fifo #(
    parameter int DIV_W      = 11,
    parameter int FIFO_DEPTH = 16,
    parameter int LVL_W      = $clog2(FIFO_DEPTH) + 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [DIV_W-1:0] div_i,
    input  logic [1:0]       data_bits_i,
    input  logic [1:0]       parity_i,
    input  logic             stop2_i,
    input  logic             wr_en_i,
    input  logic [7:0]       data_i,
    output logic             full_o,
    output logic             empty_o,
    output logic [LVL_W-1:0] level_o,
    output logic             overflow_o,
    output logic             busy_o,
    output logic             tx_idle_o,
    output logic             tx_done_o,
    output logic             tx_o
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    logic [7:0]       r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] r_wrPtr;
    logic [PTR_W-1:0] r_rdPtr;
    logic [LVL_W-1:0] r_level;
    logic             r_full;
    logic             r_empty;
    logic             r_overflow;

    state_t           r_state;
    state_t           w_nextState;
    logic [DIV_W-1:0] r_div;
    logic [DIV_W-1:0] r_tickCnt;
    logic [4:0]       r_subCnt;
    logic [2:0]       r_bitCnt;
    logic [2:0]       r_lastBit;
    logic [7:0]       r_shift;
    logic             r_parEn;
    logic             r_parity;
    logic             r_stop2;
    logic             r_tx;
    logic             r_done;

    logic             w_push;
    logic             w_pop;
    logic             w_tick;
    logic             w_bitEnd;
    logic             w_txNext;
    logic [7:0]       w_shiftNext;
    logic [7:0]       w_head;
    logic [7:0]       w_mask;
    logic [LVL_W-1:0] w_levelNext;

    // The full check uses the registered flag, so a push while full is dropped
    // even if a pop happens on the same edge.
    assign w_push   = wr_en_i && !r_full;
    assign w_head   = r_mem[r_rdPtr];
    assign w_mask   = 8'hFF >> (2'd3 - data_bits_i);
    assign w_tick   = (r_state != S_IDLE) && (r_tickCnt == r_div);
    assign w_bitEnd = w_tick &&
                      (r_subCnt == ((r_state == S_STOP && r_stop2) ? 5'd31 : 5'd15));

    // Compute the next occupancy, so that level, full and empty are all
    // registered from the same value.
    always_comb begin
        w_levelNext = r_level;
        if (w_push && !w_pop) begin
            w_levelNext = r_level + LVL_W'(1);
        end else if (!w_push && w_pop) begin
            w_levelNext = r_level - LVL_W'(1);
        end
    end

    // FIFO storage. It has no reset, because the pointers define which
    // entries are valid.
    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_mem[r_wrPtr] <= data_i;
        end
    end

    // FIFO pointers, status flags and the sticky overflow flag.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_wrPtr    <= '0;
            r_rdPtr    <= '0;
            r_level    <= '0;
            r_full     <= 1'b0;
            r_empty    <= 1'b1;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wrPtr <= r_wrPtr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rdPtr <= r_rdPtr + PTR_W'(1);
            end
            r_level <= w_levelNext;
            r_full  <= (w_levelNext == FULL_LVL);
            r_empty <= (w_levelNext == '0);
            if (wr_en_i && r_full) begin
                r_overflow <= 1'b1;
            end
        end
    end

    // Next-state and pop decision. A new frame is popped from IDLE, or
    // directly at the end of STOP so that back-to-back frames have no gap.
    always_comb begin
        w_nextState = r_state;
        w_pop       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!r_empty) begin
                    w_pop       = 1'b1;
                    w_nextState = S_START;
                end
            end
            S_START: begin
                if (w_bitEnd) begin
                    w_nextState = S_DATA;
                end
            end
            S_DATA: begin
                if (w_bitEnd && r_bitCnt == r_lastBit) begin
                    w_nextState = r_parEn ? S_PARITY : S_STOP;
                end
            end
            S_PARITY: begin
                if (w_bitEnd) begin
                    w_nextState = S_STOP;
                end
            end
            S_STOP: begin
                if (w_bitEnd) begin
                    if (!r_empty) begin
                        w_pop       = 1'b1;
                        w_nextState = S_START;
                    end else begin
                        w_nextState = S_IDLE;
                    end
                end
            end
            default: w_nextState = S_IDLE;
        endcase
    end

    // Shift-register update and the line level for the next state. The line
    // is registered so that the pin never glitches on state changes.
    always_comb begin
        w_shiftNext = r_shift;
        w_txNext    = 1'b1;
        if (w_pop) begin
            w_shiftNext = w_head;
        end else if (r_state == S_DATA && w_bitEnd) begin
            w_shiftNext = r_shift >> 1;
        end
        case (w_nextState)
            S_START:  w_txNext = 1'b0;
            S_DATA:   w_txNext = w_shiftNext[0];
            S_PARITY: w_txNext = r_parity;
            default:  w_txNext = 1'b1;
        endcase
    end

    // State register, baud/bit counters and frame configuration. The
    // configuration is latched on each pop, so mid-frame input changes only
    // affect later frames.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state   <= S_IDLE;
            r_tx      <= 1'b1;
            r_done    <= 1'b0;
            r_tickCnt <= '0;
            r_subCnt  <= '0;
            r_bitCnt  <= '0;
            r_shift   <= '0;
            r_div     <= '0;
            r_lastBit <= '0;
            r_parEn   <= 1'b0;
            r_parity  <= 1'b0;
            r_stop2   <= 1'b0;
        end else begin
            r_state <= w_nextState;
            r_tx    <= w_txNext;
            r_shift <= w_shiftNext;
            r_done  <= (r_state == S_STOP) && w_bitEnd;
            if (r_state == S_IDLE || w_tick) begin
                r_tickCnt <= '0;
            end else begin
                r_tickCnt <= r_tickCnt + DIV_W'(1);
            end
            if (r_state == S_IDLE || w_bitEnd) begin
                r_subCnt <= '0;
            end else if (w_tick) begin
                r_subCnt <= r_subCnt + 5'd1;
            end
            if (r_state != S_DATA) begin
                r_bitCnt <= '0;
            end else if (w_bitEnd) begin
                r_bitCnt <= r_bitCnt + 3'd1;
            end
            if (w_pop) begin
                r_div     <= div_i;
                r_lastBit <= 3'd4 + {1'b0, data_bits_i};
                r_parEn   <= (parity_i == 2'b01) || (parity_i == 2'b10);
                r_parity  <= (^(w_head & w_mask)) ^ (parity_i == 2'b10);
                r_stop2   <= stop2_i;
            end
        end
    end

    assign full_o     = r_full;
    assign empty_o    = r_empty;
    assign level_o    = r_level;
    assign overflow_o = r_overflow;
    assign busy_o     = (r_state != S_IDLE);
    assign tx_idle_o  = (r_state == S_IDLE) && r_empty;
    assign tx_done_o  = r_done;
    assign tx_o       = r_tx;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Testbench for uart_tx_fifo. Directed frames are checked against
// hand-built expected bit patterns and frame lengths.
module tb_uart_tx_fifo;

    logic        clk;
    logic        rst;
    logic [10:0] div;
    logic [1:0]  dataBits;
    logic [1:0]  parity;
    logic        stop2;
    logic        wrEn;
    logic [7:0]  dataIn;
    logic        full;
    logic        empty;
    logic [4:0]  level;
    logic        overflow;
    logic        busy;
    logic        txIdle;
    logic        txDone;
    logic        txO;

    int checks   = 0;
    int failures = 0;

    uart_tx_fifo #(.DIV_W(11), .FIFO_DEPTH(16)) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .div_i      (div),
        .data_bits_i(dataBits),
        .parity_i   (parity),
        .stop2_i    (stop2),
        .wr_en_i    (wrEn),
        .data_i     (dataIn),
        .full_o     (full),
        .empty_o    (empty),
        .level_o    (level),
        .overflow_o (overflow),
        .busy_o     (busy),
        .tx_idle_o  (txIdle),
        .tx_done_o  (txDone),
        .tx_o       (txO)
    );

    // 100 MHz clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Absolute time limit, so that a stuck design cannot hang the run.
    initial begin
        #2000000;
        $display("[TB] FAIL timeout: simulation time limit reached");
        $fatal(1, "[TB] timeout");
    end

    // Push one byte. The push happens on the posedge between the two
    // negedges, and the task returns on the negedge after that push.
    task automatic applyStimulus(input logic [7:0] b);
        @(negedge clk);
        dataIn = b;
        wrEn   = 1'b1;
        @(negedge clk);
        wrEn   = 1'b0;
    endtask

    // Observe one frame. The task starts on the negedge after the push. It
    // records the line just after the start edge, the line at the middle of
    // each bit, the clocks until tx_done_o is seen, and the idle flag at
    // that moment.
    task automatic watchFrame(input int nBits, input int bitT, output logic firstTx,
                              output logic [15:0] samples, output int doneDelay,
                              output logic idleAfter);
        int e;
        samples   = '0;
        doneDelay = -1;
        idleAfter = 1'b0;
        @(negedge clk);
        e = 0;
        firstTx = txO;
        while (e < (nBits + 2) * bitT) begin
            if ((e % bitT) == bitT / 2 && (e / bitT) < nBits) samples[e / bitT] = txO;
            if (txDone) begin
                doneDelay = e;
                idleAfter = txIdle;
                break;
            end
            @(negedge clk);
            e++;
        end
    endtask

    task automatic test_reset;
        rst  = 1'b1;
        wrEn = 1'b0;
        repeat (5) @(negedge clk);
        checks++; if (txO !== 1'b1) begin failures++; $display("[TB] FAIL reset_tx got=%b want=1", txO); end
        checks++; if (txIdle !== 1'b1) begin failures++; $display("[TB] FAIL reset_idle got=%b want=1", txIdle); end
        checks++; if (empty !== 1'b1) begin failures++; $display("[TB] FAIL reset_empty got=%b want=1", empty); end
        checks++; if (full !== 1'b0) begin failures++; $display("[TB] FAIL reset_full got=%b want=0", full); end
        checks++; if (level !== 5'd0) begin failures++; $display("[TB] FAIL reset_level got=%0d want=0", level); end
        checks++; if (txDone !== 1'b0) begin failures++; $display("[TB] FAIL reset_done got=%b want=0", txDone); end
        checks++; if (overflow !== 1'b0) begin failures++; $display("[TB] FAIL reset_ovf got=%b want=0", overflow); end
        checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy got=%b want=0", busy); end
        rst = 1'b0;
        @(negedge clk);
        checks++; if (txO !== 1'b1 || txIdle !== 1'b1) begin failures++; $display("[TB] FAIL post_reset tx=%b idle=%b want 1/1", txO, txIdle); end
    endtask

    task automatic test_8n1;
        logic        firstTx;
        logic [15:0] samples;
        logic [15:0] expBits;
        int          doneDelay;
        logic        idleAfter;
        div = 11'd16; dataBits = 2'b11; parity = 2'b00; stop2 = 1'b0;
        applyStimulus(8'hA5);
        checks++; if (txO !== 1'b1 || empty !== 1'b0 || level !== 5'd1) begin
            failures++; $display("[TB] FAIL push_state tx=%b empty=%b level=%0d want 1/0/1", txO, empty, level);
        end
        watchFrame(10, 272, firstTx, samples, doneDelay, idleAfter);
        expBits = {6'b0, 1'b1, 8'hA5, 1'b0};
        checks++; if (firstTx !== 1'b0) begin failures++; $display("[TB] FAIL 8n1_latency got=%b want=0", firstTx); end
        checks++; if (samples !== expBits) begin failures++; $display("[TB] FAIL 8n1_bits got=%h want=%h", samples, expBits); end
        checks++; if (doneDelay !== 2720) begin failures++; $display("[TB] FAIL 8n1_length got=%0d want=2720", doneDelay); end
        checks++; if (idleAfter !== 1'b1) begin failures++; $display("[TB] FAIL 8n1_idle got=%b want=1", idleAfter); end
        @(negedge clk);
        checks++; if (txDone !== 1'b0) begin failures++; $display("[TB] FAIL 8n1_done_width got=%b want=0", txDone); end
    endtask

    task automatic test_parity;
        logic        firstTx;
        logic [15:0] samples;
        logic [15:0] expBits;
        int          doneDelay;
        logic        idleAfter;
        // 7E2: 0x53 has four ones in its low seven bits, so the even parity bit is 0.
        div = 11'd16; dataBits = 2'b10; parity = 2'b01; stop2 = 1'b1;
        applyStimulus(8'h53);
        watchFrame(11, 272, firstTx, samples, doneDelay, idleAfter);
        expBits = {5'b0, 2'b11, 1'b0, 7'h53, 1'b0};
        checks++; if (samples !== expBits) begin failures++; $display("[TB] FAIL 7e2_bits got=%h want=%h", samples, expBits); end
        checks++; if (doneDelay !== 2992) begin failures++; $display("[TB] FAIL 7e2_length got=%0d want=2992", doneDelay); end
        // 7O2 with the configuration changed mid-frame; the frame must keep the latched settings.
        parity = 2'b10;
        fork
            begin
                repeat (40) @(negedge clk);
                div = 11'd3; dataBits = 2'b11; parity = 2'b00; stop2 = 1'b0;
            end
        join_none
        applyStimulus(8'h53);
        watchFrame(11, 272, firstTx, samples, doneDelay, idleAfter);
        expBits = {5'b0, 2'b11, 1'b1, 7'h53, 1'b0};
        checks++; if (samples !== expBits) begin failures++; $display("[TB] FAIL 7o2_bits got=%h want=%h", samples, expBits); end
        checks++; if (doneDelay !== 2992) begin failures++; $display("[TB] FAIL 7o2_length got=%0d want=2992", doneDelay); end
    endtask

    task automatic test_div0;
        logic        firstTx;
        logic [15:0] samples;
        logic [15:0] expBits;
        int          doneDelay;
        logic        idleAfter;
        div = 11'd0; dataBits = 2'b00; parity = 2'b10; stop2 = 1'b0;
        applyStimulus(8'h1F);
        watchFrame(8, 16, firstTx, samples, doneDelay, idleAfter);
        expBits = {8'b0, 1'b1, 1'b0, 5'h1F, 1'b0};
        checks++; if (firstTx !== 1'b0) begin failures++; $display("[TB] FAIL 5o1_latency got=%b want=0", firstTx); end
        checks++; if (samples !== expBits) begin failures++; $display("[TB] FAIL 5o1_bits got=%h want=%h", samples, expBits); end
        checks++; if (doneDelay !== 128) begin failures++; $display("[TB] FAIL 5o1_length got=%0d want=128", doneDelay); end
    endtask

    task automatic test_back_to_back;
        logic [7:0] sent [18];
        logic [9:0] rxBits [17];
        int         e;
        int         doneCount;
        int         badDone;
        int         lastDone;
        int         badFrame;
        div = 11'd0; dataBits = 2'b11; parity = 2'b00; stop2 = 1'b0;
        for (int i = 0; i < 18; i++) sent[i] = 8'(i * 37 + 11);
        for (int j = 0; j < 17; j++) rxBits[j] = '0;
        @(negedge clk);
        wrEn   = 1'b1;
        dataIn = sent[0];
        for (int i = 1; i < 18; i++) begin
            @(negedge clk);
            dataIn = sent[i];
            if (i == 17) begin
                checks++; if (full !== 1'b1 || overflow !== 1'b0 || level !== 5'd16) begin
                    failures++; $display("[TB] FAIL fill_full full=%b ovf=%b level=%0d want 1/0/16", full, overflow, level);
                end
            end
        end
        @(negedge clk);
        wrEn = 1'b0;
        checks++; if (full !== 1'b1 || overflow !== 1'b1 || level !== 5'd16) begin
            failures++; $display("[TB] FAIL drop_push full=%b ovf=%b level=%0d want 1/1/16", full, overflow, level);
        end
        // The first start edge was the posedge after the first push; 16 more posedges have passed.
        e = 16; doneCount = 0; badDone = 0; lastDone = -1;
        while (e < 17 * 160 + 10) begin
            if (txDone) begin
                doneCount++;
                lastDone = e;
                if ((e % 160) != 0) badDone++;
            end
            if ((e / 160) < 17 && ((e % 160) % 16) == 8) rxBits[e / 160][(e % 160) / 16] = txO;
            @(negedge clk);
            e++;
        end
        for (int j = 0; j < 17; j++) begin
            checks++; if (rxBits[j][8:1] !== sent[j]) begin
                failures++; $display("[TB] FAIL stream_byte%0d got=%h want=%h", j, rxBits[j][8:1], sent[j]);
            end
        end
        badFrame = 0;
        for (int j = 0; j < 17; j++) if (rxBits[j][0] !== 1'b0 || rxBits[j][9] !== 1'b1) badFrame++;
        checks++; if (badFrame !== 0) begin failures++; $display("[TB] FAIL stream_framing got=%0d bad frames want=0", badFrame); end
        checks++; if (doneCount !== 17) begin failures++; $display("[TB] FAIL stream_done_count got=%0d want=17", doneCount); end
        checks++; if (badDone !== 0 || lastDone !== 2720) begin
            failures++; $display("[TB] FAIL stream_done_timing misplaced=%0d last=%0d want 0/2720", badDone, lastDone);
        end
        checks++; if (txIdle !== 1'b1 || overflow !== 1'b1 || full !== 1'b0 || empty !== 1'b1) begin
            failures++; $display("[TB] FAIL stream_end idle=%b ovf=%b full=%b empty=%b want 1/1/0/1", txIdle, overflow, full, empty);
        end
    endtask

    task automatic test_reset_midframe;
        logic        firstTx;
        logic [15:0] samples;
        logic [15:0] expBits;
        int          doneDelay;
        logic        idleAfter;
        div = 11'd16; dataBits = 2'b11; parity = 2'b00; stop2 = 1'b0;
        @(negedge clk);
        wrEn   = 1'b1;
        dataIn = 8'h00;
        for (int i = 1; i < 18; i++) begin
            @(negedge clk);
            dataIn = 8'(i + 100);
        end
        @(negedge clk);
        wrEn = 1'b0;
        // Move to the middle of data bit 3 (frame bit 4) of the first frame, which carries 0.
        repeat (1224 - 16) @(negedge clk);
        checks++; if (txO !== 1'b0 || busy !== 1'b1 || overflow !== 1'b1) begin
            failures++; $display("[TB] FAIL pre_reset tx=%b busy=%b ovf=%b want 0/1/1", txO, busy, overflow);
        end
        #3;
        rst = 1'b1;
        #1;
        checks++; if (txO !== 1'b1) begin failures++; $display("[TB] FAIL async_reset_tx got=%b want=1", txO); end
        checks++; if (empty !== 1'b1 || level !== 5'd0 || full !== 1'b0) begin
            failures++; $display("[TB] FAIL async_reset_fifo empty=%b level=%0d full=%b want 1/0/0", empty, level, full);
        end
        checks++; if (overflow !== 1'b0 || busy !== 1'b0) begin
            failures++; $display("[TB] FAIL async_reset_flags ovf=%b busy=%b want 0/0", overflow, busy);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        applyStimulus(8'h3C);
        watchFrame(10, 272, firstTx, samples, doneDelay, idleAfter);
        expBits = {6'b0, 1'b1, 8'h3C, 1'b0};
        checks++; if (firstTx !== 1'b0) begin failures++; $display("[TB] FAIL after_reset_latency got=%b want=0", firstTx); end
        checks++; if (samples !== expBits) begin failures++; $display("[TB] FAIL after_reset_bits got=%h want=%h", samples, expBits); end
        checks++; if (doneDelay !== 2720 || idleAfter !== 1'b1) begin
            failures++; $display("[TB] FAIL after_reset_length got=%0d idle=%b want 2720/1", doneDelay, idleAfter);
        end
    endtask

    // Run the scenarios in order, then print the summary.
    initial begin
        rst = 1'b1; wrEn = 1'b0; dataIn = 8'h00;
        div = 11'd16; dataBits = 2'b11; parity = 2'b00; stop2 = 1'b0;
        test_reset;
        test_8n1;
        test_parity;
        test_div0;
        test_back_to_back;
        test_reset_midframe;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

Buffered, runtime-configurable UART transmitter. It is the successor to the fixed 8N1 transmitter and keeps the same 16x-oversampled baud divisor. It adds:
- a parametrised TX FIFO;
- selectable data width (5–8 bits), parity (none/even/odd) and stop bits (1/2);
- back-to-back frame streaming;
- overflow detection.

It sits between a CPU/bus register interface and the board's serial TX pin.

## Interface
Parameters:
- DIV_W, 11, width of baud divisor.
- FIFO_DEPTH, 16, FIFO entries; power of two, ≥2.
- LVL_W, $clog2(FIFO_DEPTH)+1, width of level_o (derived).

Ports:
- clk_i  in  1  system clock.
- rst_i  in  1  reset, asynchronous, active-high.
- div_i  in  DIV_W  baud divisor; oversample tick every div_i+1 clocks; 16 ticks per bit.
- data_bits_i  in  2  00=5, 01=6, 10=7, 11=8 data bits.
- parity_i  in  2  00=none, 01=even, 10=odd, 11=none.
- stop2_i  in  1  1 = two stop bits.
- wr_en_i  in  1  push request.
- data_i  in  8  byte to push; only low N bits are sent.
- full_o  out  1  FIFO full.
- empty_o  out  1  FIFO empty.
- level_o  out  LVL_W  FIFO occupancy, 0..FIFO_DEPTH.
- overflow_o  out  1  sticky; set when a push is dropped.
- busy_o  out  1  frame in progress.
- tx_idle_o  out  1  !busy_o && empty_o.
- tx_done_o  out  1  one-cycle pulse at the end of each frame's last stop bit.
- tx_o  out  1  serial line, idle high.

## Operation
- **Push.** A push is accepted iff wr_en_i && !full_o at the clock edge. The full_o check uses the pre-edge value, even if a pop happens on the same edge.
- **Dropped push.** A push while full is discarded and sets overflow_o. Only rst_i clears overflow_o.
- **Config sampling.** div_i, data_bits_i, parity_i and stop2_i are latched when a byte is popped. Changes mid-frame do not affect the current frame.
- **Baud tick counter.** Counts 0..div_latched. It is held at 0 in IDLE, so every frame starts phase-aligned.
- **FSM states:**
  - IDLE: tx_o=1.
  - START: tx_o=0, lasts 16 ticks.
  - DATA: LSB first, 16 ticks per bit, N bits.
  - PARITY: only if enabled, 16 ticks.
  - STOP: tx_o=1, 16 ticks, or 32 if stop2.
- **Parity bit.** Computed over the N sent data bits only. Even: XOR of the bits. Odd: inverted XOR.
- **Transitions:**
  - IDLE→START on the first edge with !empty_o; that same edge pops the FIFO.
  - STOP end → START if FIFO not empty (pop on the same edge, zero idle gap); otherwise → IDLE.
- **tx_done_o.** Pulses on the edge leaving STOP, once per frame.
- **Frame length.** (1+N+P+S)·16·(div+1) clocks. Example: div=16, 8N1 gives 10·272 = 2720 clocks.

## Timing
- **Reset values:**
  - tx_o=1, busy_o=0, tx_idle_o=1, tx_done_o=0;
  - empty_o=1, full_o=0, level_o=0, overflow_o=0.
  - Reset takes effect asynchronously and clears FIFO pointers and the FSM.
- **Reset mid-frame.** tx_o returns to 1 immediately and all queued data is lost. This is not an error condition.
- **Push-to-line latency.** Push at edge N into an empty FIFO with the FSM idle: empty_o falls after N, the pop happens at N+1, and tx_o falls after edge N+1.
- **Bit boundaries.** Occur every 16·(div+1) clocks after the start-bit edge, with no drift.
- **Simultaneous push and pop:**
  - If not full, level_o is unchanged.
  - If full, the push is dropped.
- **level_o, full_o, empty_o.** Registered and consistent with each other on every cycle.
- **div_i=0.** Bit period is 16 clocks; this must be supported.

## Test plan
1. Reset: hold rst_i 5 cycles → tx_o=1, tx_idle_o=1, empty_o=1, level_o=0, tx_done_o=0, overflow_o=0.
2. div=16, 8N1, push 0xA5 → tx_o low 1 cycle after push; bits 1,0,1,0,0,1,0,1 at 272-clock spacing; stop=1; tx_done_o pulses 2720 clocks after the start edge; tx_idle_o=1 afterwards.
3. div=16, 7E2, push 0x53 → data 1,1,0,0,1,0,1; parity 0; two stop bits; frame 2992 clocks. Repeat with odd parity → parity bit 1.
4. div=0, 5O1, push 0x1F → data 1,1,1,1,1; parity 0; frame 8·16 = 128 clocks.
5. FIFO_DEPTH=16, 18 consecutive pushes from idle:
   - first byte popped at once, next 16 fill the FIFO, 18th dropped → full_o=1, overflow_o=1;
   - all 17 accepted bytes appear back-to-back with no idle gap;
   - 17 tx_done_o pulses.
6. Assert rst_i during data bit 3 of a frame → tx_o=1 asynchronously, FIFO empty, overflow_o=0. After release, push 0x3C → correct 8N1 frame.
